// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// Each bit is held for max(prescale,1) clocks; all outputs are registered.
module uart_tx_frame #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     p_data,
   input  logic                      data_valid,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tx_out,
   output logic                      busy
);

   localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                    state_q, state_d;
   logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
   logic [PRESCALE_WIDTH-1:0] eff_q, eff_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      par_en_q, par_en_d;
   logic                      par_bit_q, par_bit_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      bit_done;

   assign bit_done = (cnt_q == eff_q - PRESCALE_WIDTH'(1));
   assign tx_out   = tx_q;
   assign busy     = busy_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      eff_d     = eff_q;
      idx_d     = idx_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_d      = tx_q;
      busy_d    = busy_q;

      if (state_q != StIdle) begin
         cnt_d = bit_done ? '0 : cnt_q + PRESCALE_WIDTH'(1);
      end

      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (data_valid) begin
               data_d    = p_data;
               par_en_d  = parity_enable;
               par_bit_d = (^p_data) ^ parity_type;
               eff_d     = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
               cnt_d     = '0;
               idx_d     = '0;
               state_d   = StStart;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d = StData;
               tx_d    = data_q[0];
            end
         end
         StData: begin
            if (bit_done) begin
               if (idx_q == LastIdx) begin
                  idx_d = '0;
                  if (par_en_q) begin
                     state_d = StParity;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  // Shift so the next data bit is always at position 0.
                  idx_d  = idx_q + IdxW'(1);
                  data_d = data_q >> 1;
                  tx_d   = data_d[0];
               end
            end
         end
         StParity: begin
            if (bit_done) begin
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         eff_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         eff_q     <= eff_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

endmodule
